// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM pipeline stage.
//   - Opcode constants for the byte/half/word load/store instructions.
//   - Access FSM state type and access-size type.
//   - Helpers that decode access size and load sign from an opcode.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unknown opcodes fall back to word size.
  function automatic size_t op_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      default:              sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the MEM stage.
//   op_i          opcode (selects size and load sign)
//   addr_lo_i     effective address bits [1:0]
//   st_data_i     store data before replication
//   rdata_i       memory read word
//   be_o          byte enables, bit i = lane i (little-endian)
//   wdata_o       lane-replicated store data
//   load_data_o   extracted, sign/zero-extended load value
//   misaligned_o  access not naturally aligned for its size
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  size_t       sz;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    sz       = op_size(op_i);
    sext     = op_signed(op_i);
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    be_o         = '1;
    wdata_o      = st_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;

    case (sz)
      SZ_B: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{st_data_i[7:0]}};
        load_data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{st_data_i[15:0]}};
        load_data_o  = {{16{sext & half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EXE/MEM and MEM/WB
// registers. Issues loads/stores over a req/ack data-memory port, stalls
// upstream while an access is outstanding, aborts after TIMEOUT wait
// cycles, and registers the write-back bundle.
//   clk, rst             clock; asynchronous active-low reset
//   MEM_*                instruction bundle from EXE/MEM (held while stall=1)
//   dm_rdata, dm_ack     memory response
//   dm_req, dm_we, dm_addr, dm_be, dm_wdata   memory request
//   stall                freeze upstream pipeline registers
//   WB_*                 registered write-back bundle
//   mem_exc, bus_err     registered 1-cycle misalignment / timeout pulses
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_RegW,
  input  logic        MEM_RegW_Src,
  input  logic        MEM_MemW,
  input  logic [4:0]  MEM_WBdst,
  input  logic [5:0]  MEM_instrOp,
  input  logic [31:0] MEM_Alu_C,
  input  logic [31:0] MEM_RegFileA,
  input  logic [31:0] MEM_RegFileB,
  input  logic        MEM_MEMW_src,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        stall,
  output logic        WB_RegW,
  output logic [4:0]  WB_WBdst,
  output logic [31:0] WB_Data,
  output logic [5:0]  WB_instrOp,
  output logic        mem_exc,
  output logic        bus_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        memop, acc_mis, timeout;
  logic [31:0] st_data;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;
  logic        lane_mis;

  logic        wb_regw_q, wb_regw_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [5:0]  wb_op_q, wb_op_d;
  logic        exc_q, exc_d;
  logic        berr_q, berr_d;

  assign st_data = MEM_MEMW_src ? MEM_RegFileA : MEM_RegFileB;

  mem_lane_align u_lane (
    .op_i         (MEM_instrOp),
    .addr_lo_i    (MEM_Alu_C[1:0]),
    .st_data_i    (st_data),
    .rdata_i      (dm_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load),
    .misaligned_o (lane_mis)
  );

  // Request/stall are combinational so a zero-wait ack retires the access
  // in the same cycle it is issued.
  always_comb begin
    memop   = MEM_MemW | MEM_RegW_Src;
    acc_mis = memop & lane_mis & (state_q == S_IDLE);
    dm_req  = rst & ((state_q == S_BUSY) | (memop & ~lane_mis));
    // Abort on the cycle that would be the TIMEOUT+1-th outstanding cycle:
    // the IDLE issue cycle plus TIMEOUT-1 BUSY cycles have already stalled.
    timeout = (state_q == S_BUSY) & ~dm_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
    stall   = dm_req & ~dm_ack & ~timeout;

    dm_we    = dm_req & MEM_MemW;
    dm_be    = dm_req ? lane_be : '0;
    dm_addr  = {MEM_Alu_C[31:2], 2'b00};
    dm_wdata = lane_wdata;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dm_req & ~dm_ack) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (dm_ack | timeout) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall, misalignment and timeout all retire as a bubble with the
  // previous WB payload held.
  always_comb begin
    wb_regw_d = 1'b0;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    wb_op_d   = wb_op_q;
    exc_d     = acc_mis;
    berr_d    = timeout;
    if (!(stall | acc_mis | timeout)) begin
      wb_regw_d = MEM_RegW;
      wb_dst_d  = MEM_WBdst;
      wb_op_d   = MEM_instrOp;
      wb_data_d = MEM_RegW_Src ? lane_load : MEM_Alu_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_regw_q <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      wb_op_q   <= '0;
      exc_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_regw_q <= wb_regw_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      wb_op_q   <= wb_op_d;
      exc_q     <= exc_d;
      berr_q    <= berr_d;
    end
  end

  assign WB_RegW    = wb_regw_q;
  assign WB_WBdst   = wb_dst_q;
  assign WB_Data    = wb_data_q;
  assign WB_instrOp = wb_op_q;
  assign mem_exc    = exc_q;
  assign bus_err    = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instruction sequence, a per-cycle
// reference model compared on every falling edge, and literal expectations.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_RegW, MEM_RegW_Src, MEM_MemW, MEM_MEMW_src;
  logic [4:0]  MEM_WBdst;
  logic [5:0]  MEM_instrOp;
  logic [31:0] MEM_Alu_C, MEM_RegFileA, MEM_RegFileB, dm_rdata;
  logic        dm_ack;
  logic        dm_req, dm_we, stall, WB_RegW, mem_exc, bus_err;
  logic [31:0] dm_addr, dm_wdata, WB_Data;
  logic [3:0]  dm_be;
  logic [4:0]  WB_WBdst;
  logic [5:0]  WB_instrOp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MEM_RegW(MEM_RegW), .MEM_RegW_Src(MEM_RegW_Src), .MEM_MemW(MEM_MemW),
    .MEM_WBdst(MEM_WBdst), .MEM_instrOp(MEM_instrOp), .MEM_Alu_C(MEM_Alu_C),
    .MEM_RegFileA(MEM_RegFileA), .MEM_RegFileB(MEM_RegFileB),
    .MEM_MEMW_src(MEM_MEMW_src), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .stall(stall), .WB_RegW(WB_RegW), .WB_WBdst(WB_WBdst),
    .WB_Data(WB_Data), .WB_instrOp(WB_instrOp), .mem_exc(mem_exc),
    .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [5:0] op, input int off, input logic [31:0] rd);
    logic [31:0] sh;
    int sz;
    sz = acc_size(op);
    if (sz == 1) begin
      sh = rd >> (8 * off);
      return (op == 6'h20) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end
    if (sz == 2) begin
      sh = rd >> (16 * (off / 2));
      return (op == 6'h21) ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return rd;
  endfunction

  function automatic logic [3:0] be_val(input int sz, input int off);
    if (sz == 1) return 4'b0001 << off;
    if (sz == 2) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_val(input int sz, input logic [31:0] d);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  int          pending = 0;   // cycles the current access has already waited
  logic        e_regw = 1'b0, e_exc = 1'b0, e_bus = 1'b0;
  logic [4:0]  e_dst = '0;
  logic [5:0]  e_op = '0;
  logic [31:0] e_data = '0;

  always @(negedge clk) begin
    int sz, off;
    logic memop, mis, req, tmo, stl;
    if (!rst) begin
      chk("rst_dm_req", {31'b0, dm_req}, 0);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_dm_we", {31'b0, dm_we}, 0);
      chk("rst_dm_be", {28'b0, dm_be}, 0);
      chk("rst_WB_RegW", {31'b0, WB_RegW}, 0);
      chk("rst_WB_WBdst", {27'b0, WB_WBdst}, 0);
      chk("rst_WB_Data", WB_Data, 0);
      chk("rst_WB_instrOp", {26'b0, WB_instrOp}, 0);
      chk("rst_mem_exc", {31'b0, mem_exc}, 0);
      chk("rst_bus_err", {31'b0, bus_err}, 0);
      pending = 0; e_regw = 0; e_exc = 0; e_bus = 0;
      e_dst = '0; e_op = '0; e_data = '0;
    end else begin
      sz    = acc_size(MEM_instrOp);
      off   = int'(MEM_Alu_C[1:0]);
      memop = MEM_MemW | MEM_RegW_Src;
      mis   = memop && (off % sz != 0);
      req   = (pending > 0) || (memop && !mis);
      tmo   = req && !dm_ack && (pending == TIMEOUT);
      stl   = req && !dm_ack && !tmo;
      chk("dm_req", {31'b0, dm_req}, {31'b0, req});
      chk("stall", {31'b0, stall}, {31'b0, stl});
      chk("dm_we", {31'b0, dm_we}, {31'b0, req && MEM_MemW});
      chk("dm_be", {28'b0, dm_be}, req ? {28'b0, be_val(sz, off)} : 32'b0);
      chk("dm_addr", dm_addr, MEM_Alu_C & 32'hFFFF_FFFC);
      if (req && MEM_MemW)
        chk("dm_wdata", dm_wdata,
            wdata_val(sz, MEM_MEMW_src ? MEM_RegFileA : MEM_RegFileB));
      chk("WB_RegW", {31'b0, WB_RegW}, {31'b0, e_regw});
      chk("WB_WBdst", {27'b0, WB_WBdst}, {27'b0, e_dst});
      chk("WB_Data", WB_Data, e_data);
      chk("WB_instrOp", {26'b0, WB_instrOp}, {26'b0, e_op});
      chk("mem_exc", {31'b0, mem_exc}, {31'b0, e_exc});
      chk("bus_err", {31'b0, bus_err}, {31'b0, e_bus});
      e_exc = 0; e_bus = 0; e_regw = 0;
      if (stl) begin
        pending++;
      end else if (mis) begin
        e_exc = 1;
      end else if (tmo) begin
        e_bus = 1; pending = 0;
      end else begin
        e_regw  = MEM_RegW;
        e_dst   = MEM_WBdst;
        e_op    = MEM_instrOp;
        e_data  = MEM_RegW_Src ? load_val(MEM_instrOp, off, dm_rdata) : MEM_Alu_C;
        pending = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        snap_req, snap_we;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata;
  int          sc;

  // delay >= 0: ack on that cycle; -1: never ack; -2: single cycle, no ack.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic regw, input logic src, input logic memw,
                       input logic [4:0] dst, input logic [31:0] ra,
                       input logic [31:0] rb, input logic msrc,
                       input logic [31:0] rdata, input int delay,
                       output int stall_cycles);
    int n;
    MEM_instrOp = op; MEM_Alu_C = addr; MEM_RegW = regw; MEM_RegW_Src = src;
    MEM_MemW = memw; MEM_WBdst = dst; MEM_RegFileA = ra; MEM_RegFileB = rb;
    MEM_MEMW_src = msrc; dm_rdata = rdata;
    stall_cycles = 0;
    n = (delay >= 0) ? delay + 1 : ((delay == -1) ? TIMEOUT + 1 : 1);
    for (int k = 0; k < n; k++) begin
      dm_ack = (k == delay);
      #2;
      if (k == 0) begin
        snap_req = dm_req; snap_we = dm_we; snap_be = dm_be;
        snap_addr = dm_addr; snap_wdata = dm_wdata;
      end
      if (stall) stall_cycles++;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
  endtask

  task automatic nop(input logic ack);
    MEM_instrOp = 6'h00; MEM_Alu_C = '0; MEM_RegW = 0; MEM_RegW_Src = 0;
    MEM_MemW = 0; MEM_WBdst = '0; MEM_RegFileA = '0; MEM_RegFileB = '0;
    MEM_MEMW_src = 0; dm_ack = ack;
    @(posedge clk); #1;
    dm_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    MEM_instrOp = '0; MEM_Alu_C = '0; MEM_RegW = 0; MEM_RegW_Src = 0;
    MEM_MemW = 0; MEM_WBdst = '0; MEM_RegFileA = '0; MEM_RegFileB = '0;
    MEM_MEMW_src = 0;
    @(posedge clk); #1;
    chk("lit_rst_WB_Data", WB_Data, 32'h0);
    chk("lit_rst_dm_req", {31'b0, dm_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // LW, zero-wait ack
    issue(6'h23, 32'h100, 1, 1, 0, 5'd5, 0, 0, 0, 32'hDEADBEEF, 0, sc);
    chk("lit_lw_stall_cycles", sc, 0);
    chk("lit_lw_WB_RegW", {31'b0, WB_RegW}, 1);
    chk("lit_lw_WB_Data", WB_Data, 32'hDEADBEEF);
    chk("lit_lw_WB_WBdst", {27'b0, WB_WBdst}, 5);

    // LB / LBU at 0x103, ack after 3 waits
    issue(6'h20, 32'h103, 1, 1, 0, 5'd6, 0, 0, 0, 32'h80FF_FFFF, 3, sc);
    chk("lit_lb_stall_cycles", sc, 3);
    chk("lit_lb_WB_Data", WB_Data, 32'hFFFF_FF80);
    issue(6'h24, 32'h103, 1, 1, 0, 5'd6, 0, 0, 0, 32'h80FF_FFFF, 3, sc);
    chk("lit_lbu_WB_Data", WB_Data, 32'h0000_0080);

    // LH high half, LHU low half
    issue(6'h21, 32'h102, 1, 1, 0, 5'd8, 0, 0, 0, 32'h8001_0000, 1, sc);
    chk("lit_lh_WB_Data", WB_Data, 32'hFFFF_8001);
    issue(6'h25, 32'h100, 1, 1, 0, 5'd8, 0, 0, 0, 32'h8001_F00F, 0, sc);
    chk("lit_lhu_WB_Data", WB_Data, 32'h0000_F00F);

    // SH at 0x202 from RegFileB
    issue(6'h29, 32'h202, 0, 0, 1, 5'd0, 32'h5555_5555, 32'h1234_ABCD, 0, 0, 1, sc);
    chk("lit_sh_we", {31'b0, snap_we}, 1);
    chk("lit_sh_be", {28'b0, snap_be}, 32'hC);
    chk("lit_sh_wdata", snap_wdata, 32'hABCD_ABCD);
    chk("lit_sh_addr", snap_addr, 32'h200);
    chk("lit_sh_WB_RegW", {31'b0, WB_RegW}, 0);

    // SB at 0x001 from RegFileA
    issue(6'h28, 32'h001, 0, 0, 1, 5'd0, 32'h1122_3344, 32'hFFFF_FFFF, 1, 0, 0, sc);
    chk("lit_sb_be", {28'b0, snap_be}, 32'h2);
    chk("lit_sb_wdata", snap_wdata, 32'h4444_4444);

    // Misaligned LW then an ADD (with a stray ack that must be ignored)
    issue(6'h23, 32'h101, 1, 1, 0, 5'd4, 0, 0, 0, 32'h1, -2, sc);
    chk("lit_mis_req", {31'b0, snap_req}, 0);
    chk("lit_mis_exc", {31'b0, mem_exc}, 1);
    chk("lit_mis_WB_RegW", {31'b0, WB_RegW}, 0);
    issue(6'h00, 32'h55, 1, 0, 0, 5'd7, 0, 0, 0, 0, 0, sc);
    chk("lit_add_req", {31'b0, snap_req}, 0);
    chk("lit_add_exc", {31'b0, mem_exc}, 0);
    chk("lit_add_WB_RegW", {31'b0, WB_RegW}, 1);
    chk("lit_add_WB_Data", WB_Data, 32'h55);

    // Unknown opcode load treated as word
    issue(6'h3F, 32'h40, 1, 1, 0, 5'd3, 0, 0, 0, 32'h0BAD_F00D, 0, sc);
    chk("lit_unk_WB_Data", WB_Data, 32'h0BAD_F00D);

    // Timeout
    issue(6'h23, 32'h300, 1, 1, 0, 5'd9, 0, 0, 0, 32'h7, -1, sc);
    chk("lit_tmo_stall_cycles", sc, 16);
    chk("lit_tmo_bus_err", {31'b0, bus_err}, 1);
    chk("lit_tmo_WB_RegW", {31'b0, WB_RegW}, 0);
    nop(1'b0);
    chk("lit_tmo_bus_err_clear", {31'b0, bus_err}, 0);

    // Reset during a BUSY LW (second wait cycle)
    MEM_instrOp = 6'h23; MEM_Alu_C = 32'h400; MEM_RegW = 1; MEM_RegW_Src = 1;
    MEM_MemW = 0; MEM_WBdst = 5'd10; dm_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("lit_rstmid_dm_req", {31'b0, dm_req}, 0);
    chk("lit_rstmid_stall", {31'b0, stall}, 0);
    chk("lit_rstmid_WB_Data", WB_Data, 32'h0);
    nop(1'b0);
    rst = 1'b1;
    nop(1'b1);
    #1 chk("lit_post_rst_req", {31'b0, dm_req}, 0);
    nop(1'b0);

    // Normal access after reset
    issue(6'h23, 32'h10, 1, 1, 0, 5'd11, 0, 0, 0, 32'hCAFE_F00D, 2, sc);
    chk("lit_final_WB_Data", WB_Data, 32'hCAFE_F00D);
    nop(1'b0);
    nop(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the EXE/MEM register.
- Consumes the MEM_* control/data bundle and runs byte/half/word loads and stores against a data memory with a variable-latency req/ack handshake.
- Stalls the pipeline while an access is outstanding, flags misalignment and bus timeout, and registers results into the MEM/WB bundle (WB_*) for the write-back stage.

Parameters:
- TIMEOUT, 16: max cycles an access may wait for dm_ack before abort; >=2.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_RegW  in  1  instruction writes the register file.
- MEM_RegW_Src  in  1  1 = write-back data from memory (load), 0 = ALU result.
- MEM_MemW  in  1  store instruction.
- MEM_WBdst  in  5  destination register.
- MEM_instrOp  in  6  opcode; selects access size and sign.
- MEM_Alu_C  in  32  ALU result; the effective address for memory ops.
- MEM_RegFileA  in  32  store-data candidate A.
- MEM_RegFileB  in  32  store-data candidate B.
- MEM_MEMW_src  in  1  store data select: 1 = RegFileA, 0 = RegFileB.
- dm_rdata  in  32  memory read word, valid when dm_ack=1.
- dm_ack  in  1  memory completes the current request this cycle.
- dm_req  out  1  access request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word-aligned address: {MEM_Alu_C[31:2], 2'b00}.
- dm_be  out  4  byte enables (bit i = byte lane i, little-endian).
- dm_wdata  out  32  lane-replicated store data.
- stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers.
- WB_RegW  out  1  registered write enable to write-back.
- WB_WBdst  out  5  registered destination register.
- WB_Data  out  32  registered write-back data.
- WB_instrOp  out  6  registered opcode.
- mem_exc  out  1  registered 1-cycle pulse: misaligned access.
- bus_err  out  1  registered 1-cycle pulse: access timed out.

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- memop = MEM_MemW | MEM_RegW_Src.
- Misaligned = half access with addr[0]=1, or word access with addr[1:0]!=0.
- FSM states:
  - IDLE to BUSY: memop, aligned, and no dm_ack this cycle.
  - BUSY to IDLE: dm_ack, or the wait counter reaches TIMEOUT.
  - Counter clears on entry to BUSY and increments each BUSY cycle.
- Request and stall:
  - dm_req = aligned memop while in IDLE, or state==BUSY. It is combinational, so a zero-wait ack completes in the same cycle.
  - While rst is low, dm_req is forced to 0.
  - stall = dm_req & ~dm_ack, and 0 on the timeout cycle.
  - Upstream MEM_* inputs are held stable while stall=1.
- WB register update (every clock):
  - While stall=1, insert a bubble: WB_RegW=0; the other WB_* fields hold.
  - Completed access: WB_RegW=MEM_RegW. WB_Data = extracted load data if MEM_RegW_Src=1, else MEM_Alu_C.
  - Non-memop: pass through in one cycle with no dm_req.
  - Misaligned: no dm_req, WB_RegW=0, mem_exc=1 for 1 cycle.
  - Timeout: WB_RegW=0, bus_err=1 for 1 cycle, state returns to IDLE, and the next instruction proceeds.
- Load extract from addr[1:0]:
  - LB/LBU select byte lane addr[1:0], sign-/zero-extended.
  - LH/LHU select the half at addr[1], sign-/zero-extended.
  - LW takes the whole word.
- Store:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = 4'b0011 or 4'b1100 by addr[1]; wdata = half replicated x2.
  - SW: be = 4'b1111.
  - dm_we = MEM_MemW.
  - Store completion never writes a register, since MEM_RegW=0 for stores.
- Latency: WB_* valid 1 cycle after ack (or after entry, for non-memops).
- Reset (async, rst=0):
  - state=IDLE, counter=0.
  - All WB_* outputs = 0; mem_exc=0, bus_err=0.
  - Reset mid-BUSY abandons the access. A late dm_ack arriving while in IDLE with no request is ignored.
- Unknown opcodes with memop=1 are treated as LW/SW size.

Decomposition:
- Package mem_pkg:
  - Opcode localparams (OP_LB..OP_SW).
  - State encoding (S_IDLE, S_BUSY).
  - Size enum (SZ_B, SZ_H, SZ_W).
- One combinational sub-module, mem_lane_align: opcode + addr[1:0] + store data + dm_rdata in; be, wdata, load_data, misaligned out.
- FSM, counter and WB register stay in mem_access_stage.

Test Plan:
- LW at 0x100, dm_ack asserted the same cycle as dm_req, dm_rdata=0xDEADBEEF -> stall never asserted; next cycle WB_RegW=1, WB_Data=0xDEADBEEF.
- LB at 0x103, dm_rdata=0x80FF_FFFF, ack after 3 cycles -> stall=1 for 3 cycles with WB_RegW=0 during them; then WB_Data=0xFFFF_FF80. Same access as LBU -> WB_Data=0x0000_0080.
- SH at 0x202, RegFileB=0x1234_ABCD, MEMW_src=0 -> dm_we=1, dm_be=4'b1100, dm_wdata=0xABCD_ABCD, dm_addr=0x200; WB_RegW=0.
- LW at 0x101 -> dm_req never asserted; mem_exc=1 for exactly 1 cycle; WB_RegW=0; the following ADD proceeds normally.
- LW with dm_ack never asserted, TIMEOUT=16 -> stall high for 16 cycles, then bus_err pulse, WB_RegW=0, FSM back in IDLE.
- rst driven low during a BUSY LW (cycle 2 of the wait) -> all outputs 0 immediately; after release, dm_req=0 until a new memop arrives.
